// File: rtl/aes_pkg.sv
// Shared constants and state encoding for the AES word sequencer and its helpers.
package aes_pkg;

  localparam int BLOCK_W         = 128;
  localparam int WORD_W          = 32;
  localparam int WORDS_PER_BLOCK = 4;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    LOAD    = 2'd1,
    WAIT    = 2'd2,
    EMIT    = 2'd3
  } seq_state_t;

endpackage

// File: rtl/aes_word_shift128.sv
// 128-bit register with a 32-bit MSW-first shift path and a parallel load.
module aes_word_shift128
  import aes_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               load_en,
  input  logic [BLOCK_W-1:0] load_data,
  input  logic               shift_en,
  input  logic [WORD_W-1:0]  shift_in,
  output logic [BLOCK_W-1:0] data
);

  // Load wins over shift; the two are never requested together by the sequencer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data <= '0;
    end else if (load_en) begin
      data <= load_data;
    end else if (shift_en) begin
      data <= {data[BLOCK_W-WORD_W-1:0], shift_in};
    end
  end

endmodule

// File: rtl/aes_word_sequencer.sv
// Collects four plaintext words, launches one AES block with kld, waits a fixed
// latency, then streams the 128-bit result back out as four words.
module aes_word_sequencer
  import aes_pkg::*;
#(
  parameter int AES_LATENCY = 11,
  parameter int CNT_W       = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               key_wr,
  input  logic [1:0]         key_idx,
  input  logic [WORD_W-1:0]  key_word,
  output logic               key_drop,
  input  logic [WORD_W-1:0]  s_data,
  input  logic               s_valid,
  output logic               s_ready,
  output logic [WORD_W-1:0]  m_data,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [BLOCK_W-1:0] aes_plain_text,
  output logic [BLOCK_W-1:0] aes_cipher_key,
  output logic               aes_kld,
  input  logic [BLOCK_W-1:0] aes_result,
  output logic               busy,
  output seq_state_t         fsm_state
);

  // Handshakes: a word moves on a rising edge where valid and ready are both
  // high; valid never waits on ready, and data is held stable while stalled.

  localparam logic [CNT_W-1:0] LAT_INIT = CNT_W'(AES_LATENCY - 1);

  seq_state_t         state, state_next;
  logic [1:0]         wcnt;
  logic [1:0]         ocnt;
  logic [CNT_W-1:0]   lat_cnt;
  logic [BLOCK_W-1:0] key_q;
  logic [BLOCK_W-1:0] result_q;
  logic               in_hs;
  logic               out_hs;
  logic               capture;

  assign in_hs          = s_valid & s_ready;
  assign out_hs         = m_valid & m_ready;
  assign busy           = (state != COLLECT);
  assign fsm_state      = state;
  assign aes_cipher_key = key_q;
  assign m_data         = result_q[BLOCK_W-1 -: WORD_W];

  wire unused_result = ^result_q[BLOCK_W-WORD_W-1:0];

  aes_word_shift128 u_text (
    .clk       (clk),
    .reset     (reset),
    .load_en   (1'b0),
    .load_data ({BLOCK_W{1'b0}}),
    .shift_en  (in_hs),
    .shift_in  (s_data),
    .data      (aes_plain_text)
  );

  aes_word_shift128 u_result (
    .clk       (clk),
    .reset     (reset),
    .load_en   (capture),
    .load_data (aes_result),
    .shift_en  (out_hs),
    .shift_in  ({WORD_W{1'b0}}),
    .data      (result_q)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= COLLECT;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    s_ready    = 1'b0;
    aes_kld    = 1'b0;
    m_valid    = 1'b0;
    capture    = 1'b0;
    case (state)
      COLLECT: begin
        s_ready = 1'b1;
        if (s_valid && (wcnt == 2'd3)) state_next = LOAD;
      end
      LOAD: begin
        aes_kld    = 1'b1;
        state_next = WAIT;
      end
      WAIT: begin
        if (lat_cnt == '0) begin
          capture    = 1'b1;
          state_next = EMIT;
        end
      end
      EMIT: begin
        m_valid = 1'b1;
        if (m_ready && (ocnt == 2'd3)) state_next = COLLECT;
      end
      default: state_next = COLLECT;
    endcase
  end

  // wcnt and ocnt are two bits wide, so the fourth handshake wraps them to 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wcnt    <= 2'd0;
      ocnt    <= 2'd0;
      lat_cnt <= '0;
    end else begin
      if (in_hs)  wcnt <= wcnt + 2'd1;
      if (out_hs) ocnt <= ocnt + 2'd1;
      if (state == LOAD) begin
        lat_cnt <= LAT_INIT;
      end else if ((state == WAIT) && (lat_cnt != '0)) begin
        lat_cnt <= lat_cnt - 1'b1;
      end
    end
  end

  // The key may only change between blocks; late writes are flagged, not applied.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      key_q    <= '0;
      key_drop <= 1'b0;
    end else if (key_wr) begin
      if (state == COLLECT) begin
        case (key_idx)
          2'd0:    key_q[127:96] <= key_word;
          2'd1:    key_q[95:64]  <= key_word;
          2'd2:    key_q[63:32]  <= key_word;
          default: key_q[31:0]   <= key_word;
        endcase
      end else begin
        key_drop <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_aes_word_sequencer.sv
// Directed bench for aes_word_sequencer with a stub AES core that only presents
// a valid result on the exact cycle the sequencer should capture it.
module tb_aes_word_sequencer;
  import aes_pkg::*;

  localparam int LAT  = 11;
  localparam int LAT3 = 3;

  localparam logic [127:0] KAT_KEY = 128'h00010203_04050607_08090a0b_0c0d0e0f;
  localparam logic [127:0] KAT_PT  = 128'h00112233_44556677_8899aabb_ccddeeff;
  localparam logic [127:0] KAT_CT  = 128'h69c4e0d8_6a7b0430_d8cdb780_70b4c55a;
  localparam logic [127:0] JUNK    = 128'hdeadbeef_deadbeef_deadbeef_deadbeef;

  logic         clk, reset;
  logic         key_wr;
  logic [1:0]   key_idx;
  logic [31:0]  key_word;
  logic [31:0]  s_data;
  logic         s_valid;
  logic         m_ready;

  logic         key_drop, s_ready, m_valid, aes_kld, busy;
  logic [31:0]  m_data;
  logic [127:0] aes_plain_text, aes_cipher_key, aes_result;
  seq_state_t   fsm_state;

  logic         key_drop3, s_ready3, m_valid3, aes_kld3, busy3;
  logic [31:0]  m_data3;
  logic [127:0] plain3, key3, result3;
  seq_state_t   fsm_state3;

  logic [7:0]   sc, sc3;
  int           n_cmp, n_bad;
  bit           lat3_done;
  logic [31:0]  exp_q[$];

  aes_word_sequencer #(.AES_LATENCY(LAT), .CNT_W(8)) u_dut (
    .clk(clk), .reset(reset), .key_wr(key_wr), .key_idx(key_idx), .key_word(key_word),
    .key_drop(key_drop), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .aes_plain_text(aes_plain_text), .aes_cipher_key(aes_cipher_key), .aes_kld(aes_kld),
    .aes_result(aes_result), .busy(busy), .fsm_state(fsm_state)
  );

  aes_word_sequencer #(.AES_LATENCY(LAT3), .CNT_W(8)) u_dut3 (
    .clk(clk), .reset(reset), .key_wr(key_wr), .key_idx(key_idx), .key_word(key_word),
    .key_drop(key_drop3), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready3),
    .m_data(m_data3), .m_valid(m_valid3), .m_ready(m_ready),
    .aes_plain_text(plain3), .aes_cipher_key(key3), .aes_kld(aes_kld3),
    .aes_result(result3), .busy(busy3), .fsm_state(fsm_state3)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stub core: known-answer pairs for the FIPS-197 key, a simple mix otherwise.
  function automatic logic [127:0] stub_fn(input logic [127:0] p, input logic [127:0] k);
    if (p == KAT_PT && k == KAT_KEY) return KAT_CT;
    if (p == KAT_CT && k == KAT_KEY) return KAT_PT;
    return p ^ {k[63:0], k[127:64]} ^ 128'h5a5a5a5a_c3c3c3c3_a5a5a5a5_3c3c3c3c;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) sc <= 8'd0;
    else if (aes_kld) sc <= 8'd1;
    else if (sc != 8'd0 && sc != 8'hff) sc <= sc + 8'd1;
  end
  assign aes_result = (sc == 8'(LAT)) ? stub_fn(aes_plain_text, aes_cipher_key) : JUNK;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) sc3 <= 8'd0;
    else if (aes_kld3) sc3 <= 8'd1;
    else if (sc3 != 8'd0 && sc3 != 8'hff) sc3 <= sc3 + 8'd1;
  end
  assign result3 = (sc3 == 8'(LAT3)) ? stub_fn(plain3, key3) : JUNK;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Driver tasks
  task automatic write_key(input logic [127:0] k);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      key_wr   = 1'b1;
      key_idx  = 2'(i);
      key_word = k[127-32*i -: 32];
    end
    @(negedge clk);
    key_wr = 1'b0;
  endtask

  task automatic send_words(input logic [127:0] blk, input bit gappy, input bit kw_last,
                            input logic [31:0] kw_val);
    int gap;
    for (int i = 0; i < 4; i++) begin
      gap = gappy ? int'($urandom_range(0, 5)) : 0;
      repeat (gap) begin
        @(negedge clk);
        s_valid = 1'b0;
        check("kld_early", 128'(aes_kld), 128'(0));
      end
      @(negedge clk);
      check("kld_early", 128'(aes_kld), 128'(0));
      check("s_ready_collect", 128'(s_ready), 128'(1));
      s_valid = 1'b1;
      s_data  = blk[127-32*i -: 32];
      if (kw_last && i == 3) begin
        key_wr   = 1'b1;
        key_idx  = 2'd3;
        key_word = kw_val;
      end
    end
    @(negedge clk);
    s_valid = 1'b0;
    key_wr  = 1'b0;
    check("kld_pulse", 128'(aes_kld), 128'(1));
    check("plain_text", aes_plain_text, blk);
    check("state_load", 128'(fsm_state), 128'(LOAD));
  endtask

  task automatic wait_result(input logic [127:0] blk, input logic [127:0] key_exp, input bit kdrop);
    int n, kx;
    n = 0;
    kx = 0;
    do begin
      @(negedge clk);
      n++;
      if (aes_kld) kx++;
      if (kdrop && n == 3) begin
        key_wr   = 1'b1;
        key_idx  = 2'd0;
        key_word = 32'hffffffff;
        s_valid  = 1'b1;
        s_data   = 32'hbad0bad0;
      end
      if (kdrop && n == 4) begin
        key_wr  = 1'b0;
        s_valid = 1'b0;
        check("key_drop_set", 128'(key_drop), 128'(1));
        check("key_stable", aes_cipher_key, key_exp);
        check("s_ready_wait", 128'(s_ready), 128'(0));
        check("busy_wait", 128'(busy), 128'(1));
      end
    end while (!m_valid && n < 300);
    check("latency", 128'(n - 1), 128'(LAT));
    check("kld_width", 128'(kx), 128'(0));
    check("plain_hold", aes_plain_text, blk);
    check("key_hold", aes_cipher_key, key_exp);
  endtask

  task automatic recv_block(input logic [127:0] exp_blk, input bit bp);
    logic [31:0] held, w;
    bit          stalled;
    bit          pat[4];
    int          got, c;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) exp_q.push_back(exp_blk[127-32*i -: 32]);
    got = 0;
    c = 0;
    stalled = 1'b0;
    held = '0;
    while (got < 4 && c < 200) begin
      @(negedge clk);
      if (stalled) check("hold", 128'(m_data), 128'(held));
      m_ready = bp ? pat[c % 4] : 1'b1;
      c++;
      check("s_ready_emit", 128'(s_ready), 128'(0));
      if (m_valid && m_ready) begin
        w = exp_q.pop_front();
        check("m_data", 128'(m_data), 128'(w));
        got++;
        stalled = 1'b0;
      end else begin
        stalled = m_valid;
        held    = m_data;
      end
    end
    check("emit_count", 128'(got), 128'(4));
    exp_q.delete();
    @(negedge clk);
    m_ready = 1'b0;
    check("m_valid_done", 128'(m_valid), 128'(0));
    check("s_ready_after", 128'(s_ready), 128'(1));
    check("busy_after", 128'(busy), 128'(0));
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_s_ready"}, 128'(s_ready), 128'(1));
    check({tag, "_m_valid"}, 128'(m_valid), 128'(0));
    check({tag, "_kld"}, 128'(aes_kld), 128'(0));
    check({tag, "_busy"}, 128'(busy), 128'(0));
    check({tag, "_m_data"}, 128'(m_data), 128'(0));
    check({tag, "_key_drop"}, 128'(key_drop), 128'(0));
    check({tag, "_plain"}, aes_plain_text, 128'(0));
    check({tag, "_key"}, aes_cipher_key, 128'(0));
    check({tag, "_state"}, 128'(fsm_state), 128'(COLLECT));
  endtask

  // Short-latency instance: measure its first block only.
  initial begin
    int t, n;
    lat3_done = 1'b0;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!(aes_kld3 && !reset) && t < 2000);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!m_valid3 && n < 300);
    check("latency3", 128'(n - 1), 128'(LAT3));
    check("m_data3", 128'(m_data3), 128'(32'h69c4e0d8));
    lat3_done = 1'b1;
  end

  // Main sequence and final report
  initial begin
    logic [127:0] k2, k2_mod, blk3, blk4, blk5;
    int mv_seen;
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b1;
    key_wr = 1'b0;
    key_idx = 2'd0;
    key_word = '0;
    s_data = '0;
    s_valid = 1'b0;
    m_ready = 1'b0;
    k2     = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;
    k2_mod = 128'h2b7e1516_28aed2a6_abf71588_11223344;
    blk3   = 128'h0f1e2d3c_4b5a6978_8796a5b4_c3d2e1f0;
    blk4   = 128'hfedcba98_76543210_01234567_89abcdef;
    blk5   = 128'h3243f6a8_885a308d_313198a2_e0370734;

    repeat (2) @(negedge clk);
    check_reset_state("rst");
    reset = 1'b0;
    @(negedge clk);

    write_key(KAT_KEY);
    check("key_loaded", aes_cipher_key, KAT_KEY);

    // Known-answer encrypt, no gaps, no backpressure
    send_words(KAT_PT, 1'b0, 1'b0, 32'h0);
    wait_result(KAT_PT, KAT_KEY, 1'b0);
    recv_block(KAT_CT, 1'b0);

    // Decrypt direction, gappy input, backpressured output
    send_words(KAT_CT, 1'b1, 1'b0, 32'h0);
    wait_result(KAT_CT, KAT_KEY, 1'b0);
    recv_block(KAT_PT, 1'b1);

    // Key write and stray s_valid while busy
    send_words(blk3, 1'b0, 1'b0, 32'h0);
    wait_result(blk3, KAT_KEY, 1'b1);
    recv_block(stub_fn(blk3, KAT_KEY), 1'b1);
    check("key_drop_sticky", 128'(key_drop), 128'(1));

    // Next block still uses the original key
    send_words(blk4, 1'b1, 1'b0, 32'h0);
    wait_result(blk4, KAT_KEY, 1'b0);
    recv_block(stub_fn(blk4, KAT_KEY), 1'b0);

    // Asynchronous reset while waiting on the core
    send_words(blk5, 1'b0, 1'b0, 32'h0);
    repeat (4) @(negedge clk);
    check("state_wait", 128'(fsm_state), 128'(WAIT));
    @(posedge clk);
    #3 reset = 1'b1;
    #1 check_reset_state("async_rst");
    #2 reset = 1'b0;
    mv_seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (m_valid) mv_seen++;
    end
    check("no_m_valid_after_rst", 128'(mv_seen), 128'(0));
    check("s_ready_after_rst", 128'(s_ready), 128'(1));

    // Fresh block; a key write alongside the fourth word is accepted
    write_key(k2);
    send_words(blk5, 1'b1, 1'b1, 32'h11223344);
    check("key_last_word", aes_cipher_key, k2_mod);
    check("key_drop_clear", 128'(key_drop), 128'(0));
    wait_result(blk5, k2_mod, 1'b0);
    recv_block(stub_fn(blk5, k2_mod), 1'b1);

    check("lat3_done", 128'(lat3_done), 128'(1));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/aes_word_sequencer.md
Name: aes_word_sequencer

Overview:
- Front-end sequencer for the AES core. Accepts 32-bit plaintext words over a valid/ready stream and holds a 128-bit cipher key written through a word port.
- Once four words are collected, it drives the 128-bit block and key into the AES datapath and pulses kld. It then waits a fixed latency and returns the 128-bit result as four 32-bit words over an output valid/ready stream.
- Sits directly upstream of the unrolled encrypt/decrypt core and feeds it.

Parameters:
- AES_LATENCY, 11, cycles from the kld pulse to a valid aes_result (range 1..255).
- CNT_W, 8, width of the latency counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- key_wr  in  1  key word write strobe.
- key_idx  in  2  key word index; 0 = bits [127:96], 3 = bits [31:0].
- key_word  in  32  key word data.
- key_drop  out  1  sticky flag: a key write was ignored because the block was busy.
- s_data  in  32  plaintext word; first word = bits [127:96].
- s_valid  in  1  plaintext word valid.
- s_ready  out  1  sequencer can accept a plaintext word.
- m_data  out  32  result word; first word = bits [127:96].
- m_valid  out  1  result word valid.
- m_ready  in  1  downstream accepts the result word.
- aes_plain_text  out  128  block presented to the AES core.
- aes_cipher_key  out  128  key presented to the AES core.
- aes_kld  out  1  one-cycle load pulse to the AES core.
- aes_result  in  128  AES core output (cipher_text or aes_output).
- busy  out  1  high in any state other than COLLECT.

Behaviour:
- Reset (asynchronous, immediate):
  - state = COLLECT; word and latency counters = 0.
  - Text, key and result registers = 0; key_drop = 0.
  - s_ready = 1, m_valid = 0, aes_kld = 0, busy = 0, m_data = 0.
  - Reset mid-operation abandons the block; no partial output is emitted.
- Key port:
  - In COLLECT, key_wr writes key_word into the slot selected by key_idx on the clock edge.
  - In any other state the write is ignored and key_drop sets; key_drop clears only on reset.
  - aes_cipher_key is the key register and is stable while busy.
- COLLECT:
  - s_ready = 1. Each s_valid & s_ready handshake shifts the word into the text register, MSW first, and increments wcnt (0..3).
  - The handshake with wcnt = 3 moves to LOAD and wraps wcnt to 0.
  - A key write in the same cycle as the fourth text word is accepted (still in COLLECT).
- LOAD: exactly one cycle.
  - aes_kld = 1; aes_plain_text holds the full block; s_ready = 0.
  - Latency counter is loaded with AES_LATENCY - 1; move to WAIT.
- WAIT:
  - Counter decrements each cycle. When it is 0, aes_result is captured into the result register and the state moves to EMIT.
  - The capture edge is exactly AES_LATENCY cycles after the LOAD cycle's edge.
- EMIT:
  - m_valid = 1 and m_data = result[127:96] first.
  - Each m_valid & m_ready handshake shifts the next word; m_data stays stable while m_ready = 0.
  - After the fourth handshake: m_valid = 0, next state COLLECT, s_ready = 1 on the following cycle. There is no overlap between EMIT and COLLECT.
- aes_plain_text holds its value from LOAD through the end of EMIT; it changes only on COLLECT shifts.
- s_valid outside COLLECT is ignored (no handshake, since s_ready = 0).
- Throughput: at best one block per 4 + 1 + AES_LATENCY + 4 cycles.

Decomposition:
- Shared package aes_pkg:
  - constants BLOCK_W = 128, WORD_W = 32, WORDS_PER_BLOCK = 4;
  - state encoding COLLECT = 2'd0, LOAD = 2'd1, WAIT = 2'd2, EMIT = 2'd3.
- One natural sub-module: aes_word_shift128, a 128-bit register with 32-bit MSW-first shift-in and shift-out plus a parallel load. It is instantiated twice: text collect and result emit.

Test Plan:
- Known-answer vector, bench wraps the sequencer around full_aes:
  - Stimulus: key words 00010203, 04050607, 08090a0b, 0c0d0e0f; text words 00112233, 44556677, 8899aabb, ccddeeff.
  - Required response: cipher words 69c4e0d8, 6a7b0430, d8cdb780, 70b4c55a; decrypt output returns 00112233..ccddeeff.
- Latency check, stub core returning a fixed pattern:
  - Required: aes_kld is high exactly 1 cycle, and the capture occurs exactly 11 cycles after it.
  - With AES_LATENCY = 3, capture occurs exactly 3 cycles after the pulse.
- Backpressure:
  - Stimulus: m_ready toggles 1,0,0,1 during EMIT.
  - Required: m_data holds each word while stalled, all 4 words are delivered in order, s_ready stays 0 until after the fourth handshake.
- Gappy input:
  - Stimulus: s_valid deasserted between words for 0..5 random cycles.
  - Required: the block assembles correctly and aes_kld fires only after the fourth handshake.
- Key write while busy:
  - Stimulus: key_wr with key_idx = 0, key_word = ffffffff during WAIT.
  - Required: key_drop = 1, aes_cipher_key unchanged, the next block still uses the old key.
- Reset mid-WAIT:
  - Stimulus: assert reset asynchronously (between clock edges).
  - Required: outputs zero immediately, s_ready = 1 after release, no m_valid; a fresh block then completes normally.
